// File: rtl/serial_bit_tx.sv
// serial_bit_tx: frames a parallel word onto a one-bit line as
// start(0), data LSB first, stop(1), each bit held BIT_CYCLES clocks.
//
// state | meaning
// ------+--------------------------------------------------
// IDLE  | line high, ready for a new word
// START | start bit (line low)
// DATA  | data bits, LSB first, from shift_reg[0]
// STOP  | stop bit (line high); done pulses on the way out
//
// The two-bit state encoding is fully used; the default branch still
// forces IDLE so a corrupted state register cannot strand the line.
module serial_bit_tx #(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             d_out,
  output logic             busy,
  output logic             done
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shift_reg, shift_nxt, shifted;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [BW-1:0]    bit_idx, bit_nxt;
  logic             d_out_nxt, ready_nxt, busy_nxt, done_nxt;
  logic             last_cycle;

  // State and datapath registers; every output is driven from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      cnt       <= '0;
      bit_idx   <= '0;
      d_out     <= 1'b1;
      ready     <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_nxt;
      cnt       <= cnt_nxt;
      bit_idx   <= bit_nxt;
      d_out     <= d_out_nxt;
      ready     <= ready_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

  // Next-state and next-output logic; outputs are computed one cycle
  // ahead so that the registered value matches the state being entered.
  always_comb begin
    state_nxt  = state;
    shift_nxt  = shift_reg;
    cnt_nxt    = cnt;
    bit_nxt    = bit_idx;
    d_out_nxt  = d_out;
    ready_nxt  = ready;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    last_cycle = (cnt == CNT_LAST);
    shifted    = shift_reg >> 1;

    case (state)
      IDLE: begin
        d_out_nxt = 1'b1;
        ready_nxt = 1'b1;
        busy_nxt  = 1'b0;
        if (load && ready) begin
          state_nxt = START;
          shift_nxt = data_in;
          cnt_nxt   = '0;
          bit_nxt   = '0;
          d_out_nxt = 1'b0;
          ready_nxt = 1'b0;
          busy_nxt  = 1'b1;
        end
      end

      START: begin
        if (last_cycle) begin
          state_nxt = DATA;
          cnt_nxt   = '0;
          d_out_nxt = shift_reg[0];
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      DATA: begin
        if (last_cycle) begin
          cnt_nxt   = '0;
          shift_nxt = shifted;
          if (bit_idx == BIT_LAST) begin
            state_nxt = STOP;
            bit_nxt   = '0;
            d_out_nxt = 1'b1;
          end else begin
            bit_nxt   = bit_idx + 1'b1;
            d_out_nxt = shifted[0];
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      STOP: begin
        if (last_cycle) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          d_out_nxt = 1'b1;
          ready_nxt = 1'b1;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
        shift_nxt = '0;
        cnt_nxt   = '0;
        bit_nxt   = '0;
        d_out_nxt = 1'b1;
        ready_nxt = 1'b1;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule
